// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the run/step sequencer.
//   MODE_*              : FSM state encodings, also driven on the mode output
//   *_DEF               : default parameter values for the top level
package cpu_ctrl_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    localparam int DEBOUNCE_TICKS_DEF = 20;
    localparam int RUN_DIV_DEF        = 50;
    localparam int CNT_W_DEF          = 16;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// CPU-side signals of the run/step sequencer.
//   cpu_halt : halt request from the CPU core (level)
//   cpu_ce   : one-cycle CPU clock-enable
//   mode     : current sequencer state
//   ce_count : number of cpu_ce pulses since reset, wrapping
// master = sequencer, slave = CPU core / display side.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16
) ();

    logic             cpu_halt;
    logic             cpu_ce;
    logic [1:0]       mode;
    logic [CNT_W-1:0] ce_count;

    modport master (input cpu_halt, output cpu_ce, output mode, output ce_count);
    modport slave  (output cpu_halt, input cpu_ce, input mode, input ce_count);

endinterface

// File: rtl/cpu_run_ctrl_debounce.sv
// Push-button debouncer: 2-flop synchroniser, tick-sampled stability counter,
// and a one-cycle pulse on an accepted 0->1 transition.
//   clk_50MHz : system clock
//   rst       : asynchronous active-low reset
//   tick_i    : sampling strobe
//   btn_i     : raw asynchronous button (active-high)
//   press_o   : one-cycle pulse when a press is accepted
module btn_debounce #(
    parameter int TICKS = 20
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int             CW       = $clog2(TICKS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick_i) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // this tick is the TICKS-th consecutive differing sample
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse in the cycle the new level is being accepted, so the FSM acts on
    // the same edge that updates stable_q.
    assign press_o = stable_d & ~stable_q;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: debounces the step and run buttons and issues a
// one-cycle CPU clock-enable, single in STEP, periodic in RUN, stopping on a
// CPU halt request. Counts issued enables for the display.
//   clk_50MHz : system clock
//   rst       : asynchronous active-low reset
//   tick_1kHz : debounce sampling strobe
//   btn_step  : raw step button
//   btn_run   : raw run/stop button
//   bus       : cpu_halt in; cpu_ce, mode, ce_count out
//
// state     | meaning
// ----------+-------------------------------------------------
// MODE_IDLE | waiting for a press, no enables
// MODE_STEP | single enable issuing this cycle, back to IDLE
// MODE_RUN  | enable every RUN_DIV cycles until run pressed
// MODE_HALT | CPU requested halt, waits for cpu_halt to drop
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int RUN_DIV        = RUN_DIV_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic           clk_50MHz,
    input  logic           rst,
    input  logic           tick_1kHz,
    input  logic           btn_step,
    input  logic           btn_run,
    cpu_run_ctrl_if.master bus
);

    localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             step_press, run_press;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0] ce_count_q, ce_count_d;

    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_step (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .tick_i    (tick_1kHz),
        .btn_i     (btn_step),
        .press_o   (step_press)
    );

    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_run (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .tick_i    (tick_1kHz),
        .btn_i     (btn_run),
        .press_o   (run_press)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cpu_ce_d   = 1'b0;
        ce_count_d = ce_count_q + CNT_W'(cpu_ce_q);
        case (state_q)
            MODE_IDLE: begin
                if (run_press) begin
                    state_d = MODE_RUN;
                    div_d   = '0;
                end else if (step_press) begin
                    state_d  = MODE_STEP;
                    cpu_ce_d = 1'b1;
                end
            end
            MODE_STEP: begin
                state_d = MODE_IDLE;
            end
            MODE_RUN: begin
                div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                // a stop press on the terminal cycle still lets that pulse out
                cpu_ce_d = (div_q == DIV_LAST);
                if (run_press) begin
                    state_d = MODE_IDLE;
                end
            end
            default: begin
                if (!bus.cpu_halt) begin
                    state_d = MODE_IDLE;
                end
            end
        endcase
        // Halt beats everything; an enable already registered still completes.
        if (bus.cpu_halt) begin
            state_d  = MODE_HALT;
            cpu_ce_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state_q    <= MODE_IDLE;
            div_q      <= '0;
            cpu_ce_q   <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cpu_ce_q   <= cpu_ce_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign bus.cpu_ce   = cpu_ce_q;
    assign bus.mode     = state_q;
    assign bus.ce_count = ce_count_q;

endmodule
